sobel_edge_engine: RTL and testbench
====================================

Name: sobel_edge_engine

Overview:
- Parametrised streaming Sobel edge engine for the OV5640 ISP path, on the luma (Y) stream that feeds the RGB565 display/SDRAM writer.
- Generalises the fixed 8-bit, hard-threshold Sobel stage:
  - configurable pixel width and line length;
  - internal line buffers with row/column tracking and explicit border handling;
  - runtime threshold;
  - four output modes, latched per frame;
  - fixed, documented latency with a frame-done marker.

Parameters:
- PIX_W, 8: luma bit width; legal range 6..12.
- IMG_W, 640: pixels per line; line-buffer depth.
- IMG_H, 480: lines per frame.
- MAG_W, PIX_W+3: magnitude width; holds |Gx|+|Gy| with no overflow.

Ports:
- sys_clk  in  1  single clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- pix_valid  in  1  input pixel beat.
- pix_data  in  PIX_W  luma, raster order.
- frame_start  in  1  qualifies a pix_valid beat as pixel (0,0).
- thr  in  MAG_W  edge threshold.
- mode  in  2  0=binary, 1=inverted binary, 2=gray magnitude, 3=luma passthrough.
- out_valid  out  1  output beat.
- out_data  out  16  RGB565 result.
- out_sof  out  1  marks output of pixel (0,0).
- frame_done  out  1  marks output of pixel (IMG_H-1, IMG_W-1).

Behaviour:
- Reset: synchronous, active-low. On any sys_clk edge with sys_rst_n=0:
  - all outputs, counters, window and pipeline registers go to 0;
  - shadow mode=0, shadow thr=0;
  - line-buffer RAM contents are don't-care.
  - A reset asserted mid-frame drops all in-flight beats. After release, no output appears until the next frame_start.
- Window:
  - Counters col (0..IMG_W-1) and row (0..IMG_H-1) advance only on pix_valid.
  - col wraps to 0 and increments row. row wraps to 0 after IMG_H-1.
  - frame_start with pix_valid forces col=row=0 for that beat, even mid-frame (restart). Beats already in flight drain normally.
  - pix_valid beats before the first frame_start after reset are ignored.
  - Window for beat (r,c) is rows r-2..r, cols c-2..c, so its centre is (r-1,c-1). The output image is therefore offset by one row and one column; this is intended.
  - Border: if r<2 or c<2, the magnitude is forced to 0.
- Arithmetic:
  - Gx = (P13+2P23+P33) - (P11+2P21+P31).
  - Gy = (P11+2P12+P13) - (P31+2P32+P33).
  - mag = |Gx|+|Gy|, unsigned MAG_W bits. No square root.
- Pipeline: 5 stages.
  - S1: window shift.
  - S2: weighted row/column sums.
  - S3: absolute differences.
  - S4: magnitude.
  - S5: format.
  - out_valid, out_sof and frame_done follow pix_valid by exactly 5 cycles.
  - Gaps in pix_valid are allowed. The window shifts only on valid beats; the data pipeline runs every cycle.
  - No backpressure.
- Frame latch: mode and thr are captured into shadow registers on the frame_start beat. Changes mid-frame have no effect until the next frame_start.
- Format:
  - mode 0: mag>=thr gives 16'h0000, else 16'hFFFF.
  - mode 1: the inverse of mode 0.
  - mode 2: g = min(mag, 2^PIX_W-1); out = {g[PIX_W-1 -: 5], g[PIX_W-1 -: 6], g[PIX_W-1 -: 5]}.
  - mode 3: same packing as mode 2, using the centre pixel P22.
  - When out_valid=0, out_data holds its last value.
- out_sof and frame_done are single-beat, coincident with out_valid.
  - With IMG_W=IMG_H=1 both assert together.
  - A restart suppresses frame_done for the truncated frame.

Decomposition:
- Package sobel_pkg:
  - mode encodings MODE_BIN, MODE_BIN_INV, MODE_GRAY, MODE_PASS;
  - BLACK=16'h0000, WHITE=16'hFFFF;
  - constant PIPE_LAT=5;
  - function for the RGB565 gray packing.
- Sub-module sobel_win3x3:
  - contains the two IMG_W x PIX_W line buffers, the col/row counters and the 3x3 window registers;
  - outputs the nine taps, a tap-valid flag and border/sof/last flags.
- The top level holds S2-S5 and the shadow registers.

Test Plan:
- Flat frame: IMG_W=8, IMG_H=6, all pixels 100, mode 0, thr 12 -> 48 beats, all 16'hFFFF; out_sof on beat 0; frame_done on beat 47; each output 5 cycles after its input.
- Vertical step: cols 0-3=0, cols 4-7=200, mode 0, thr 12 -> for rows 2..5, beats at c=4,5 give mag 800 and out 16'h0000; all others 16'hFFFF. mode 2 -> those beats 16'hFFFF (saturated 255), others 16'h0000.
- Border: random frame, mode 2 -> every beat with r<2 or c<2 outputs 16'h0000.
- Gaps and latch: the step frame with pix_valid every other cycle -> output sequence identical to the gapless run. mode 0->1 changed at beat 20 -> output unchanged until the next frame_start, then inverted.
- Restart/reset: frame_start at beat 30 of a frame -> new out_sof 5 cycles later and no frame_done for the aborted frame. sys_rst_n low for 1 cycle mid-frame -> out_valid=0 next edge; pixels are ignored until frame_start.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared constants and helpers for the Sobel edge engine.
// Mode encodings, RGB565 colours and gray packing.
package sobel_pkg;

  localparam logic [1:0] MODE_BIN     = 2'd0;
  localparam logic [1:0] MODE_BIN_INV = 2'd1;
  localparam logic [1:0] MODE_GRAY    = 2'd2;
  localparam logic [1:0] MODE_PASS    = 2'd3;

  localparam logic [15:0] BLACK = 16'h0000;
  localparam logic [15:0] WHITE = 16'hFFFF;

  localparam int PIPE_LAT = 5;

  // v is left-aligned in 12 bits so any PIX_W up to 12 packs alike
  function automatic logic [15:0] gray565(input logic [11:0] v);
    return {v[11:7], v[11:6], v[11:7]};
  endfunction

endpackage

// File: rtl/sobel_win3x3.sv
// Line buffers, raster position tracking and 3x3 window (stage S1).
// Taps p<row><col>: row 1 is two lines up, col 3 is the newest column.
module sobel_win3x3
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             frame_start,
  output logic [PIX_W-1:0] p11,
  output logic [PIX_W-1:0] p12,
  output logic [PIX_W-1:0] p13,
  output logic [PIX_W-1:0] p21,
  output logic [PIX_W-1:0] p22,
  output logic [PIX_W-1:0] p23,
  output logic [PIX_W-1:0] p31,
  output logic [PIX_W-1:0] p32,
  output logic [PIX_W-1:0] p33,
  output logic             tap_valid,
  output logic             border,
  output logic             sof,
  output logic             last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] lb2 [IMG_W];

  logic [CW-1:0] ncol;
  logic [CW-1:0] col;
  logic [RW-1:0] nrow;
  logic [RW-1:0] row;
  logic          active;
  logic          take;
  logic          col_end;
  logic          row_end;

  // Beats before the first frame_start after reset are dropped
  assign take    = pix_valid && (frame_start || active);
  assign col     = frame_start ? '0 : ncol;
  assign row     = frame_start ? '0 : nrow;
  assign col_end = (int'(col) == IMG_W - 1);
  assign row_end = (int'(row) == IMG_H - 1);

  always_ff @(posedge clk) begin
    if (take) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ncol      <= '0;
      nrow      <= '0;
      active    <= 1'b0;
      tap_valid <= 1'b0;
      border    <= 1'b0;
      sof       <= 1'b0;
      last      <= 1'b0;
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
    end else begin
      tap_valid <= take;
      sof       <= take && frame_start;
      last      <= take && col_end && row_end;
      if (take) begin
        active <= 1'b1;
        border <= (int'(row) < 2) || (int'(col) < 2);
        p11 <= p12; p12 <= p13; p13 <= lb2[col];
        p21 <= p22; p22 <= p23; p23 <= lb1[col];
        p31 <= p32; p32 <= p33; p33 <= pix_data;
        if (col_end) begin
          ncol <= '0;
          nrow <= row_end ? '0 : row + 1'b1;
        end else begin
          ncol <= col + 1'b1;
          nrow <= row;
        end
      end
    end
  end

endmodule

// File: rtl/sobel_edge_engine.sv
// Streaming Sobel edge engine: window, sums, abs, magnitude, format.
// Mode/threshold are latched per frame and travel with each beat.
module sobel_edge_engine
  import sobel_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int MAG_W = PIX_W + 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             frame_start,
  input  logic [MAG_W-1:0] thr,
  input  logic [1:0]       mode,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_sof,
  output logic             frame_done
);

  localparam int SW = PIX_W + 2;
  localparam logic [PIX_W-1:0] PMAX = {PIX_W{1'b1}};

  logic [PIX_W-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic             tv;
  logic             tb;
  logic             ts;
  logic             tl;

  sobel_win3x3 #(
    .PIX_W(PIX_W),
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_win (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .frame_start(frame_start),
    .p11(p11), .p12(p12), .p13(p13),
    .p21(p21), .p22(p22), .p23(p23),
    .p31(p31), .p32(p32), .p33(p33),
    .tap_valid  (tv),
    .border     (tb),
    .sof        (ts),
    .last       (tl)
  );

  logic [1:0]       sh_mode;
  logic [MAG_W-1:0] sh_thr;

  logic [4:2]                   vq, sq, lq;
  logic [3:2]                   bq;
  logic [4:2][1:0]              mq;
  logic [4:2][MAG_W-1:0]        tq;
  logic [4:2][PIX_W-1:0]        cq;
  logic [SW-1:0]                s2_xp, s2_xn, s2_yp, s2_yn;
  logic [SW-1:0]                s3_gx, s3_gy;
  logic [MAG_W-1:0]             s4_mag;

  logic [PIX_W-1:0] gsat;
  logic             hit;
  logic [15:0]      fmt;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      sh_mode <= '0;
      sh_thr  <= '0;
    end else if (pix_valid && frame_start) begin
      sh_mode <= mode;
      sh_thr  <= thr;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      vq <= '0; sq <= '0; lq <= '0; bq <= '0;
      mq <= '0; tq <= '0; cq <= '0;
      s2_xp <= '0; s2_xn <= '0; s2_yp <= '0; s2_yn <= '0;
      s3_gx <= '0; s3_gy <= '0;
      s4_mag <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      vq[2] <= tv; sq[2] <= ts; lq[2] <= tl; bq[2] <= tb;
      mq[2] <= sh_mode; tq[2] <= sh_thr; cq[2] <= p22;
      vq[4:3] <= vq[3:2]; sq[4:3] <= sq[3:2]; lq[4:3] <= lq[3:2];
      mq[4:3] <= mq[3:2]; tq[4:3] <= tq[3:2]; cq[4:3] <= cq[3:2];
      bq[3] <= bq[2];

      s2_xp <= SW'(p13) + SW'({p23, 1'b0}) + SW'(p33);
      s2_xn <= SW'(p11) + SW'({p21, 1'b0}) + SW'(p31);
      s2_yp <= SW'(p11) + SW'({p12, 1'b0}) + SW'(p13);
      s2_yn <= SW'(p31) + SW'({p32, 1'b0}) + SW'(p33);

      s3_gx <= (s2_xp >= s2_xn) ? s2_xp - s2_xn : s2_xn - s2_xp;
      s3_gy <= (s2_yp >= s2_yn) ? s2_yp - s2_yn : s2_yn - s2_yp;

      s4_mag <= bq[3] ? '0 : MAG_W'(s3_gx) + MAG_W'(s3_gy);

      out_valid  <= vq[4];
      out_sof    <= sq[4];
      frame_done <= lq[4];
      if (vq[4]) out_data <= fmt;
    end
  end

  always_comb begin
    gsat = (s4_mag > MAG_W'(PMAX)) ? PMAX : s4_mag[PIX_W-1:0];
    hit  = (s4_mag >= tq[4]);
    fmt  = BLACK;
    unique case (1'b1)
      (mq[4] == MODE_BIN):     fmt = hit ? BLACK : WHITE;
      (mq[4] == MODE_BIN_INV): fmt = hit ? WHITE : BLACK;
      (mq[4] == MODE_GRAY):    fmt = gray565(12'(gsat) << (12 - PIX_W));
      (mq[4] == MODE_PASS):    fmt = gray565(12'(cq[4]) << (12 - PIX_W));
    endcase
  end

endmodule

// File: tb/tb_sobel_edge_engine.sv
// Directed bench for sobel_edge_engine on an 8x6 frame, 8-bit luma.
// Outputs are logged at negedge and checked per scenario.
module tb_sobel_edge_engine;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int N  = W * H;
  localparam int MW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pix_valid = 1'b0;
  logic [7:0]    pix_data = '0;
  logic          frame_start = 1'b0;
  logic [MW-1:0] thr = '0;
  logic [1:0]    mode = '0;
  logic          out_valid;
  logic [15:0]   out_data;
  logic          out_sof;
  logic          frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  img [H][W];
  logic [15:0] oq [$];
  logic [15:0] ref_q [$];
  bit          sq [$];
  bit          dq [$];
  int          ocq [$];
  int          icq [$];

  sobel_edge_engine #(
    .PIX_W(8),
    .IMG_W(W),
    .IMG_H(H),
    .MAG_W(MW)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .frame_start(frame_start),
    .thr        (thr),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid) begin
      oq.push_back(out_data);
      sq.push_back(out_sof);
      dq.push_back(frame_done);
      ocq.push_back(cyc);
    end
  end

  function automatic logic [15:0] model(int r, int c, logic [1:0] m, logic [MW-1:0] t);
    int gx, gy, mag, g;
    logic [7:0]  g8;
    logic [15:0] bin;
    mag = 0;
    if (r >= 2 && c >= 2) begin
      gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
         - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
      gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
         - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
      mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    end
    g   = (mag > 255) ? 255 : mag;
    g8  = g[7:0];
    bin = (mag >= int'(t)) ? 16'h0000 : 16'hFFFF;
    case (m)
      2'd0: return bin;
      2'd1: return ~bin;
      2'd2: return {g8[7:3], g8[7:2], g8[7:3]};
      default: begin
        g8 = img[r-1][c-1];
        return {g8[7:3], g8[7:2], g8[7:3]};
      end
    endcase
  endfunction

  task automatic clear_q();
    oq.delete(); sq.delete(); dq.delete(); ocq.delete(); icq.delete();
  endtask

  task automatic beat(input logic [7:0] d, input bit fs,
                      input logic [1:0] m, input logic [MW-1:0] t);
    @(negedge clk);
    pix_valid = 1'b1; pix_data = d; frame_start = fs;
    mode = m; thr = t;
    icq.push_back(cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pix_valid = 1'b0; frame_start = 1'b0;
      pix_data = 8'hA5;
    end
  endtask

  task automatic send(input int nb, input bit gaps, input int chg,
                      input logic [1:0] m, input logic [1:0] m2,
                      input logic [MW-1:0] t, input logic [MW-1:0] t2);
    for (int b = 0; b < nb; b++) begin
      if (b >= chg) beat(img[(b/W)%H][b%W], b == 0, m2, t2);
      else          beat(img[(b/W)%H][b%W], b == 0, m, t);
      if (gaps) idle(1);
    end
  endtask

  task automatic fill_step();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c >= 4) ? 8'd200 : 8'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_assert += 4;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid);
    end
    if (out_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0000", out_data);
    end
    if (out_sof !== 1'b0) begin
      n_fail++; $display("FAIL reset_sof: got %b expected 0", out_sof);
    end
    if (frame_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b expected 0", frame_done);
    end
    rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 6; i++) beat(8'd50, 1'b0, 2'd0, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != 0) begin
      n_fail++; $display("FAIL pre_sof_ignored: got %0d beats expected 0", oq.size());
    end
  endtask

  task automatic test_flat();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'd100;
    clear_q();
    send(N, 0, N, 2'd0, 2'd0, 11'd12, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != N) begin
      n_fail++; $display("FAIL flat_count: got %0d expected %0d", oq.size(), N);
    end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      n_assert += 4;
      if (oq[k] !== 16'hFFFF) begin
        n_fail++; $display("FAIL flat_data[%0d]: got %h expected ffff", k, oq[k]);
      end
      if (sq[k] !== (k == 0)) begin
        n_fail++; $display("FAIL flat_sof[%0d]: got %b expected %b", k, sq[k], k == 0);
      end
      if (dq[k] !== (k == N-1)) begin
        n_fail++; $display("FAIL flat_done[%0d]: got %b expected %b", k, dq[k], k == N-1);
      end
      if (ocq[k] - icq[k] != 5) begin
        n_fail++; $display("FAIL flat_lat[%0d]: got %0d expected 5", k, ocq[k] - icq[k]);
      end
    end
  endtask

  task automatic test_step();
    logic [15:0] e;
    fill_step();
    clear_q();
    send(N, 0, N, 2'd0, 2'd0, 11'd12, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != N) begin
      n_fail++; $display("FAIL step_bin_count: got %0d expected %0d", oq.size(), N);
    end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      e = ((k/W) >= 2 && ((k%W) == 4 || (k%W) == 5)) ? 16'h0000 : 16'hFFFF;
      n_assert++;
      if (oq[k] !== e) begin
        n_fail++; $display("FAIL step_bin[%0d]: got %h expected %h", k, oq[k], e);
      end
    end
    ref_q = oq;
    clear_q();
    send(N, 0, N, 2'd2, 2'd2, 11'd12, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != N) begin
      n_fail++; $display("FAIL step_gray_count: got %0d expected %0d", oq.size(), N);
    end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      e = ((k/W) >= 2 && ((k%W) == 4 || (k%W) == 5)) ? 16'hFFFF : 16'h0000;
      n_assert++;
      if (oq[k] !== e) begin
        n_fail++; $display("FAIL step_gray[%0d]: got %h expected %h", k, oq[k], e);
      end
    end
  endtask

  task automatic test_border();
    logic [15:0] e;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 8'($urandom_range(0, 255));
    clear_q();
    send(N, 0, N, 2'd2, 2'd2, 11'd0, 11'd0);
    idle(10);
    n_assert++;
    if (oq.size() != N) begin
      n_fail++; $display("FAIL border_count: got %0d expected %0d", oq.size(), N);
    end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      e = model(k/W, k%W, 2'd2, 11'd0);
      n_assert++;
      if (oq[k] !== e) begin
        n_fail++; $display("FAIL border_gray[%0d]: got %h expected %h", k, oq[k], e);
      end
    end
    clear_q();
    send(N, 0, N, 2'd3, 2'd3, 11'd0, 11'd0);
    idle(10);
    for (int k = 0; k < N && k < oq.size(); k++) begin
      if ((k/W) >= 1 && (k%W) >= 1) begin
        e = model(k/W, k%W, 2'd3, 11'd0);
        n_assert++;
        if (oq[k] !== e) begin
          n_fail++; $display("FAIL pass[%0d]: got %h expected %h", k, oq[k], e);
        end
      end
    end
  endtask

  task automatic test_gaps();
    fill_step();
    clear_q();
    send(N, 1, N, 2'd0, 2'd0, 11'd12, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != N) begin
      n_fail++; $display("FAIL gap_count: got %0d expected %0d", oq.size(), N);
    end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      n_assert += 2;
      if (oq[k] !== ref_q[k]) begin
        n_fail++; $display("FAIL gap_data[%0d]: got %h expected %h", k, oq[k], ref_q[k]);
      end
      if (ocq[k] - icq[k] != 5) begin
        n_fail++; $display("FAIL gap_lat[%0d]: got %0d expected 5", k, ocq[k] - icq[k]);
      end
    end
  endtask

  task automatic test_latch();
    fill_step();
    clear_q();
    send(N, 0, 20, 2'd0, 2'd1, 11'd12, 11'd2000);
    idle(10);
    n_assert++;
    if (oq.size() != N) begin
      n_fail++; $display("FAIL latch_count: got %0d expected %0d", oq.size(), N);
    end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      n_assert++;
      if (oq[k] !== ref_q[k]) begin
        n_fail++; $display("FAIL latch_hold[%0d]: got %h expected %h", k, oq[k], ref_q[k]);
      end
    end
    clear_q();
    send(N, 0, N, 2'd1, 2'd1, 11'd12, 11'd12);
    idle(10);
    for (int k = 0; k < N && k < oq.size(); k++) begin
      n_assert++;
      if (oq[k] !== ~ref_q[k]) begin
        n_fail++; $display("FAIL latch_inv[%0d]: got %h expected %h", k, oq[k], ~ref_q[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    fill_step();
    clear_q();
    send(30, 0, N, 2'd0, 2'd0, 11'd12, 11'd12);
    send(N, 0, N, 2'd0, 2'd0, 11'd12, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != 30 + N) begin
      n_fail++; $display("FAIL restart_count: got %0d expected %0d", oq.size(), 30 + N);
    end
    for (int k = 0; k < 30 + N && k < oq.size(); k++) begin
      n_assert += 3;
      if (oq[k] !== ref_q[k < 30 ? k : k - 30]) begin
        n_fail++; $display("FAIL restart_data[%0d]: got %h", k, oq[k]);
      end
      if (sq[k] !== (k == 0 || k == 30)) begin
        n_fail++; $display("FAIL restart_sof[%0d]: got %b expected %b", k, sq[k], k == 0 || k == 30);
      end
      if (dq[k] !== (k == 29 + N)) begin
        n_fail++; $display("FAIL restart_done[%0d]: got %b expected %b", k, dq[k], k == 29 + N);
      end
    end
    if (oq.size() > 30) begin
      n_assert++;
      if (ocq[30] - icq[30] != 5) begin
        n_fail++; $display("FAIL restart_sof_lat: got %0d expected 5", ocq[30] - icq[30]);
      end
    end
  endtask

  task automatic test_mid_reset();
    fill_step();
    clear_q();
    send(20, 0, N, 2'd0, 2'd0, 11'd12, 11'd12);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_assert += 2;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_valid: got %b expected 0", out_valid);
    end
    if (out_data !== 16'h0000) begin
      n_fail++; $display("FAIL midrst_data: got %h expected 0000", out_data);
    end
    rst_n = 1'b1;
    clear_q();
    for (int i = 0; i < 10; i++) beat(img[2][i%W], 1'b0, 2'd0, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != 0) begin
      n_fail++; $display("FAIL midrst_ignored: got %0d beats expected 0", oq.size());
    end
    clear_q();
    send(N, 0, N, 2'd0, 2'd0, 11'd12, 11'd12);
    idle(10);
    n_assert++;
    if (oq.size() != N) begin
      n_fail++; $display("FAIL midrst_count: got %0d expected %0d", oq.size(), N);
    end
    for (int k = 0; k < N && k < oq.size(); k++) begin
      n_assert++;
      if (oq[k] !== ref_q[k]) begin
        n_fail++; $display("FAIL midrst_data[%0d]: got %h expected %h", k, oq[k], ref_q[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_flat();
    test_step();
    test_border();
    test_gaps();
    test_latch();
    test_back_to_back();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
